// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer, LSB first, with a one-word hold register so a new word can be queued while the current one drains.
// Latency 1 cycle from accept to first bit; serial_ready low freezes the current bit, and parallel_ready drops only while the hold register is full.
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last,
    input  logic             serial_ready
);

    localparam int cnt_w = $clog2(width);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width - 1);

    logic [width-1:0] shift_reg;
    logic [width-1:0] hold_reg;
    logic [cnt_w-1:0] bit_cnt;
    logic             busy;
    logic             hold_valid;

    logic accept;
    logic xfer;
    logic at_last;

    assign parallel_ready = !hold_valid;
    assign accept         = parallel_valid && !hold_valid;
    assign xfer           = busy && serial_ready;
    assign at_last        = (bit_cnt == last_cnt);

    assign serial_valid = busy;
    assign serial_data  = shift_reg[0];
    assign serial_last  = busy && at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            hold_reg   <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            hold_valid <= 1'b0;
        end else if (!busy) begin
            if (accept) begin
                shift_reg <= parallel_data;
                bit_cnt   <= '0;
                busy      <= 1'b1;
            end
        end else if (xfer && at_last) begin
            // Word boundary: the held word has priority; hold_valid implies no accept this cycle.
            bit_cnt <= '0;
            if (hold_valid) begin
                shift_reg  <= hold_reg;
                hold_valid <= 1'b0;
            end else if (accept) begin
                shift_reg <= parallel_data;
            end else begin
                shift_reg <= '0;
                busy      <= 1'b0;
            end
        end else begin
            if (xfer) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (accept) begin
                hold_reg   <= parallel_data;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule
